adc128s_spi_model: RTL and testbench

Cycle-based model of an 8-channel, 12-bit SPI A2D converter, clocked by the system clock. The equalizer's potentiometer reader talks to it over SPI mode 0. Each frame returns the conversion for the channel addressed in the previous frame. Channel values are deterministic and self-decrementing, so the reader's results can be checked exactly.

---
 rtl/adc128s_spi_model.sv | 85 ++++++++
 tb/tb_adc128s_spi_model.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/adc128s_spi_model.sv
// Cycle-based model of an 8-channel 12-bit SPI A2D converter (SPI mode 0).
// Each frame returns the channel addressed by the previous frame; channel values decrement per read.
module adc128s_spi_model #(
    parameter logic [11:0] BASE      = 12'hC00,
    parameter logic [11:0] CH_OFFSET = 12'h010,
    parameter logic [11:0] STEP      = 12'h010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       frame_done,
    output logic [2:0] cur_ch
);

    logic        sclk_p0, sclk_p1;
    logic        ss_p0, ss_p1;
    logic        mosi_p0;
    logic [15:0] tx;
    logic [15:0] rx;
    logic [4:0]  bitcnt;
    logic [11:0] values [8];

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic unused_rx_bits;

    // Edges compare synchronizer stage 1 against stage 2
    assign sclk_rise = sclk_p0 & ~sclk_p1;
    assign sclk_fall = ~sclk_p0 & sclk_p1;
    assign ss_fall   = ~ss_p0 & ss_p1;
    assign ss_rise   = ss_p0 & ~ss_p1;

    assign MISO = tx[15] & ~ss_p1;

    // Only the channel-select field of the command is decoded
    assign unused_rx_bits = ^{rx[15:14], rx[10:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p0    <= 1'b0;
            sclk_p1    <= 1'b0;
            ss_p0      <= 1'b1;
            ss_p1      <= 1'b1;
            mosi_p0    <= 1'b0;
            tx         <= 16'h0000;
            rx         <= 16'h0000;
            bitcnt     <= 5'd0;
            cur_ch     <= 3'd0;
            frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                values[i] <= BASE + CH_OFFSET * 12'(i);
            end
        end else begin
            sclk_p0    <= SCLK;
            sclk_p1    <= sclk_p0;
            ss_p0      <= SS_n;
            ss_p1      <= ss_p0;
            mosi_p0    <= MOSI;
            frame_done <= 1'b0;

            if (ss_fall) begin
                tx     <= {4'b0000, values[cur_ch]};
                rx     <= 16'h0000;
                bitcnt <= 5'd0;
            end else if (ss_rise) begin
                // Partial or aborted frames leave channel state untouched
                if (bitcnt == 5'd16) begin
                    values[cur_ch] <= values[cur_ch] - STEP;
                    cur_ch         <= rx[13:11];
                    frame_done     <= 1'b1;
                end
            end else if (!ss_p1) begin
                if (sclk_rise && bitcnt < 5'd16) begin
                    rx     <= {rx[14:0], mosi_p0};
                    bitcnt <= bitcnt + 5'd1;
                end else if (sclk_fall && bitcnt != 5'd0 && bitcnt < 5'd16) begin
                    tx <= {tx[14:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Directed bench for adc128s_spi_model: table of SPI frames plus reset/abort/wrap sequences.
module tb_adc128s_spi_model;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso_a, miso_b;
    logic       done_a, done_b;
    logic [2:0] ch_a, ch_b;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    logic [15:0] rd_a, rd_b;

    always #5 clk = ~clk;

    adc128s_spi_model dut_a (
        .clk(clk), .rst(rst), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
        .MISO(miso_a), .frame_done(done_a), .cur_ch(ch_a)
    );

    adc128s_spi_model #(.BASE(12'h010)) dut_b (
        .clk(clk), .rst(rst), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
        .MISO(miso_b), .frame_done(done_b), .cur_ch(ch_b)
    );

    always @(negedge clk) begin
        if (done_a === 1'b1) pulses_a++;
        if (done_b === 1'b1) pulses_b++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits SCLK periods of one frame; MISO captured just before each rise.
    task automatic spi_bits(input logic [15:0] cmd, input int nbits);
        rd_a = 16'h0000;
        rd_b = 16'h0000;
        for (int k = 0; k < nbits; k++) begin
            mosi = cmd[15-k];
            wait_clk(8);
            rd_a = {rd_a[14:0], miso_a};
            rd_b = {rd_b[14:0], miso_b};
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(8);
    endtask

    task automatic frame(input logic [15:0] cmd, input int nbits);
        ss_n = 1'b0;
        wait_clk(8);
        spi_bits(cmd, nbits);
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clk(10);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
    endtask

    typedef struct {
        logic [15:0] cmd;
        int          nbits;
        logic [15:0] exp_rd;
        int          exp_pulses;
        logic [2:0]  exp_ch;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int p0;

        vecs[0] = '{16'h1800, 16, 16'h0C00, 1, 3'd3};
        vecs[1] = '{16'h1800, 16, 16'h0C30, 1, 3'd3};
        vecs[2] = '{16'h1800, 16, 16'h0C20, 1, 3'd3};
        vecs[3] = '{16'h3800, 16, 16'h0C10, 1, 3'd7};
        vecs[4] = '{16'hFFFF, 16, 16'h0C70, 1, 3'd7};
        vecs[5] = '{16'hC7FF, 16, 16'h0C60, 1, 3'd0};
        vecs[6] = '{16'h0000, 16, 16'h0BF0, 1, 3'd0};
        vecs[7] = '{16'h1800,  9, 16'h0017, 0, 3'd0};
        vecs[8] = '{16'h0000, 16, 16'h0BE0, 1, 3'd0};

        do_reset();
        check("reset_miso", {15'd0, miso_a}, 16'h0000);
        check("reset_done", {15'd0, done_a}, 16'h0000);
        check("reset_ch",   {13'd0, ch_a},   16'h0000);

        for (int i = 0; i < 9; i++) begin
            p0 = pulses_a;
            frame(vecs[i].cmd, vecs[i].nbits);
            check($sformatf("vec%0d_rd", i), rd_a, vecs[i].exp_rd);
            check($sformatf("vec%0d_pulses", i), 16'(pulses_a - p0), 16'(vecs[i].exp_pulses));
            check($sformatf("vec%0d_ch", i), {13'd0, ch_a}, {13'd0, vecs[i].exp_ch});
            check($sformatf("vec%0d_miso_idle", i), {15'd0, miso_a}, 16'h0000);
        end

        // Extra SCLK rises beyond 16 must not disturb the selection
        ss_n = 1'b0;
        wait_clk(8);
        spi_bits(16'h1000, 16);
        spi_bits(16'hFFFF, 3);
        ss_n = 1'b1;
        wait_clk(10);
        check("extra_rises_ch", {13'd0, ch_a}, 16'h0002);
        frame(16'h0000, 16);
        check("extra_rises_next_rd", rd_a, 16'h0C20);

        // Channel 0 wraps below zero with BASE = 0x010
        do_reset();
        frame(16'h0000, 16);
        check("wrap_rd0", rd_b, 16'h0010);
        frame(16'h0000, 16);
        check("wrap_rd1", rd_b, 16'h0000);
        p0 = pulses_b;
        frame(16'h0000, 16);
        check("wrap_rd2", rd_b, 16'h0FF0);
        check("wrap_pulses", 16'(pulses_b - p0), 16'h0001);

        // Reset asserted mid-frame after 5 bits
        do_reset();
        frame(16'h1800, 16);
        check("pre_rst_ch", {13'd0, ch_a}, 16'h0003);
        ss_n = 1'b0;
        wait_clk(8);
        spi_bits(16'h2000, 5);
        p0 = pulses_a;
        rst = 1'b1;
        wait_clk(2);
        check("midrst_miso", {15'd0, miso_a}, 16'h0000);
        check("midrst_ch",   {13'd0, ch_a},   16'h0000);
        ss_n = 1'b1;
        sclk = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);
        check("midrst_pulses", 16'(pulses_a - p0), 16'h0000);
        frame(16'h0000, 16);
        check("midrst_next_rd", rd_a, 16'h0C00);
        check("midrst_next_ch", {13'd0, ch_a}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
